// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for an external N-input reduction gate.
// Drives every input vector, compares against a golden model, reports pass/fail.
module gate_sweep_checker #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         dut_f,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] fail_vec,
    output logic         fail_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0]   LAST  = 4'(SETTLE - 1);
    localparam logic [N-1:0] ONE_V = N'(1);
    localparam logic [N:0]   ONE_E = (N + 1)'(1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   op_q, op_d;
    logic [N-1:0] vec_q, vec_d;
    logic [N:0]   err_q, err_d;
    logic [N-1:0] fvec_q, fvec_d;
    logic         fvalid_q, fvalid_d;
    logic         pass_q, pass_d;
    logic         expected;
    logic         mismatch;
    logic         op_legal;

    always_comb begin
        expected = 1'b0;
        unique case (op_q)
            3'b000:  expected = &vec_q;
            3'b001:  expected = |vec_q;
            3'b010:  expected = ~&vec_q;
            3'b011:  expected = ~|vec_q;
            3'b100:  expected = ^vec_q;
            3'b101:  expected = ~^vec_q;
            default: expected = 1'b0;
        endcase
    end

    assign mismatch = (dut_f != expected);
    assign op_legal = (op < 3'd6);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                    vec_d    = '0;
                    cnt_d    = '0;
                    state_d  = op_legal ? APPLY : DONE;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (mismatch) begin
                        err_d = err_q + ONE_E;
                        if (!fvalid_q) begin
                            fvec_d   = vec_q;
                            fvalid_d = 1'b1;
                        end
                    end
                    if (&vec_q) begin
                        // Pass must account for a mismatch on this last vector.
                        pass_d  = !mismatch && (err_q == '0);
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + ONE_V;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
            pass_q   <= pass_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = (state_q == APPLY);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: truth-table gate models, vector table,
// randomized runs against an arithmetic reference, reset and restart cases.
module tb_gate_sweep_checker;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [15:0]  tt = 16'h0;
    logic         sel_m = 1'b0;

    logic         dut_f_a, dut_f_b;
    logic [N-1:0] vec_a, vec_b, fvec_a, fvec_b;
    logic         busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic         fvalid_a, fvalid_b;
    logic [N:0]   err_a, err_b;

    logic [N-1:0] m_vec, m_fvec;
    logic         m_busy, m_done, m_pass, m_fvalid;
    logic [N:0]   m_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dut_f_a = tt[vec_a];
    assign dut_f_b = tt[vec_b];

    assign m_vec    = sel_m ? vec_b    : vec_a;
    assign m_fvec   = sel_m ? fvec_b   : fvec_a;
    assign m_busy   = sel_m ? busy_b   : busy_a;
    assign m_done   = sel_m ? done_b   : done_a;
    assign m_pass   = sel_m ? pass_b   : pass_a;
    assign m_fvalid = sel_m ? fvalid_b : fvalid_a;
    assign m_err    = sel_m ? err_b    : err_a;

    gate_sweep_checker #(.N(N), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .op(op), .dut_f(dut_f_a),
        .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .fail_vec(fvec_a), .fail_valid(fvalid_a)
    );

    gate_sweep_checker #(.N(N), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .op(op), .dut_f(dut_f_b),
        .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .fail_vec(fvec_b), .fail_valid(fvalid_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Golden function from counting ones, not from reduction operators.
    function automatic bit ref_f(input logic [2:0] o, input int v);
        int ones;
        ones = 0;
        for (int b = 0; b < N; b++) ones += (v >> b) & 1;
        case (o)
            3'd0: return ones == N;
            3'd1: return ones != 0;
            3'd2: return ones != N;
            3'd3: return ones == 0;
            3'd4: return (ones % 2) == 1;
            3'd5: return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_run(input logic [2:0] o, input logic [15:0] t,
                             output int e_err, output int e_fvec,
                             output int e_fvalid, output int e_pass);
        e_err = 0; e_fvec = 0; e_fvalid = 0; e_pass = 0;
        if (o <= 3'd5) begin
            for (int v = 0; v < (1 << N); v++) begin
                if (t[v] != ref_f(o, v)) begin
                    if (e_err == 0) begin
                        e_fvec = v;
                        e_fvalid = 1;
                    end
                    e_err++;
                end
            end
            e_pass = (e_err == 0);
        end
    endtask

    task automatic set_start(input int sel, input logic val);
        if (sel == 1) start_b = val;
        else start_a = val;
    endtask

    task automatic run_check(input int sel, input logic [2:0] o,
                             input logic [15:0] t, input int restart,
                             input int e_err, input int e_fvec,
                             input int e_fvalid, input int e_pass,
                             input string tag);
        int nb, got, done_at, settle, legal, busy_after;
        settle = (sel == 1) ? 3 : 1;
        legal = (o <= 3'd5);
        @(negedge clk);
        sel_m = sel[0];
        op = o;
        tt = t;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        op = 3'($urandom);
        nb = 0; got = 0; done_at = -1;
        for (int c = 0; c < 400 && got == 0; c++) begin
            if (c == restart) set_start(sel, 1'b1);
            else if (c == restart + 1) set_start(sel, 1'b0);
            if (m_done) begin
                got = 1;
                done_at = c;
            end else begin
                if (m_busy) nb++;
                @(negedge clk);
            end
        end
        set_start(sel, 1'b0);
        chk({tag, " done_seen"}, got, 1);
        chk({tag, " busy_cycles"}, nb, legal ? 16 * settle : 0);
        chk({tag, " done_at"}, done_at, legal ? 16 * settle : 0);
        chk({tag, " busy_in_done"}, int'(m_busy), 0);
        chk({tag, " err_cnt"}, int'(m_err), e_err);
        chk({tag, " fail_vec"}, int'(m_fvec), e_fvec);
        chk({tag, " fail_valid"}, int'(m_fvalid), e_fvalid);
        chk({tag, " pass"}, int'(m_pass), e_pass);
        chk({tag, " vec_final"}, int'(m_vec), legal ? 15 : 0);
        @(negedge clk);
        chk({tag, " done_pulse_end"}, int'(m_done), 0);
        chk({tag, " pass_held"}, int'(m_pass), e_pass);
        busy_after = 0;
        for (int c = 0; c < 3; c++) begin
            if (m_busy || m_done) busy_after = 1;
            @(negedge clk);
        end
        chk({tag, " no_requeue"}, busy_after, 0);
        chk({tag, " vec_held"}, int'(m_vec), legal ? 15 : 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] tt;
        int          sel;
        int          restart;
        int          err;
        int          fvec;
        int          fvalid;
        int          pass;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e_err, e_fvec, e_fvalid, e_pass, seen_done;
        logic [2:0]  ro;
        logic [15:0] rt;
        int rs;

        tbl[0] = '{3'd2, 16'h7FFF, 0, -1, 0, 0, 0, 1};
        tbl[1] = '{3'd2, 16'hFFFF, 0, -1, 1, 15, 1, 0};
        tbl[2] = '{3'd2, 16'h0001, 0, -1, 14, 1, 1, 0};
        tbl[3] = '{3'd6, 16'h7FFF, 0, -1, 0, 0, 0, 0};
        tbl[4] = '{3'd4, 16'h6996, 1, 10, 0, 0, 0, 1};
        tbl[5] = '{3'd7, 16'h0000, 1, -1, 0, 0, 0, 0};
        tbl[6] = '{3'd0, 16'h8000, 1, -1, 0, 0, 0, 1};
        tbl[7] = '{3'd5, 16'h9669, 0, -1, 0, 0, 0, 1};

        repeat (2) @(negedge clk);
        chk("reset vec", int'(vec_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset done", int'(done_b), 0);
        chk("reset err", int'(err_b), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_check(tbl[i].sel, tbl[i].op, tbl[i].tt, tbl[i].restart,
                      tbl[i].err, tbl[i].fvec, tbl[i].fvalid, tbl[i].pass,
                      $sformatf("tbl%0d", i));

        @(negedge clk);
        sel_m = 1'b0;
        op = 3'd2;
        tt = 16'h0001;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 50 && vec_a != 4'h7; c++) @(negedge clk);
        chk("rst reach_vec7", int'(vec_a), 7);
        chk("rst pre_err", int'(err_a), 6);
        rst = 1'b1;
        #1;
        chk("rst vec", int'(vec_a), 0);
        chk("rst busy", int'(busy_a), 0);
        chk("rst done", int'(done_a), 0);
        chk("rst pass", int'(pass_a), 0);
        chk("rst err", int'(err_a), 0);
        chk("rst fail_vec", int'(fvec_a), 0);
        chk("rst fail_valid", int'(fvalid_a), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_a || busy_a) seen_done = 1;
            @(negedge clk);
        end
        chk("rst no_done", seen_done, 0);
        run_check(0, 3'd2, 16'h7FFF, -1, 0, 0, 0, 1, "post_rst");

        for (int i = 0; i < 16; i++) begin
            rs = int'($urandom_range(0, 1));
            ro = 3'($urandom_range(0, 7));
            rt = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int v = 0; v < 16; v++) rt[v] = ref_f(ro, v);
                if ($urandom_range(0, 1) == 1) rt[$urandom_range(0, 15)] ^= 1'b1;
            end
            model_run(ro, rt, e_err, e_fvec, e_fvalid, e_pass);
            run_check(rs, ro, rt, -1, e_err, e_fvec, e_fvalid, e_pass,
                      $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Parametrised successor to the 4-input NAND lab gate. It drives every 2^N input combination onto an external N-input gate under test and compares the gate's output with an internal golden model for the selected reduction function. It counts mismatches, captures the first failing vector and reports pass/fail with a start/done handshake. It sits beside lab gate designs as a synthesizable self-checker, replacing hand-written per-vector stimulus lists.

Parameters:
N, 4, number of gate inputs; legal range 1..8
SETTLE, 1, cycles each vector is held before dut_f is sampled; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  run request; sampled only in IDLE
op  input  3  function select: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR; 110/111 illegal
dut_f  input  1  output of the external gate under test (combinational from vec)
vec  output  N  registered stimulus to the gate under test
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at end of run
pass  output  1  result of last run; held until the next accepted start
err_cnt  output  N+1  mismatch count of current/last run, range 0..2^N
fail_vec  output  N  first mismatching vector
fail_valid  output  1  fail_vec holds a captured vector

Behaviour:
- Reset (async, any state, mid-run included): state=IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_valid=0; settle counter=0. A run aborted by reset produces no done.
- States: IDLE, APPLY, DONE.
- IDLE: busy=0. On an edge with start=1:
  - Latch op into op_l; clear err_cnt, fail_valid, fail_vec and pass; set vec=0 and settle counter=0.
  - Legal op: go to APPLY, busy=1 from the next cycle.
  - Illegal op: go to DONE directly, busy stays 0, pass stays 0.
- APPLY: settle counter increments each cycle. On the edge where counter==SETTLE-1:
  - Compare dut_f with expected(vec, op_l).
  - Expected: AND = &vec; OR = |vec; NAND = ~&vec; NOR = ~|vec; XOR = ^vec; XNOR = ~^vec.
  - On mismatch: err_cnt += 1. If fail_valid=0, set fail_vec=vec and fail_valid=1; later mismatches do not overwrite.
  - If vec=all-ones, go to DONE. Otherwise vec += 1 and counter=0.
  - vec never wraps within a run.
  - err_cnt is N+1 bits wide, so it cannot overflow.
- DONE: lasts exactly 1 cycle.
  - done=1, busy=0.
  - pass=1 iff the op was legal and the final err_cnt=0, including any mismatch on the last vector.
  - Next state is IDLE.
- Latency: start accepted at edge k; busy is high for 2^N*SETTLE cycles; done is high for one cycle immediately after. An illegal op gives done in the cycle after acceptance.
- start is ignored in APPLY and DONE; it is not queued.
- If start is held high, a new run is accepted on the first IDLE edge after DONE.
- vec holds its final value after a run until the next accepted start.
- op changes during a run have no effect, because op_l is used.

Test Plan:
1. N=4, SETTLE=1, ideal NAND model on dut_f, op=010, start pulse -> busy 16 cycles, then done pulse; pass=1, err_cnt=0, fail_valid=0.
2. dut_f tied 1, op=010 -> only vec=4'hF mismatches; err_cnt=1, fail_vec=4'hF, fail_valid=1, pass=0.
3. Ideal NOR model on dut_f, op=010 -> mismatches at 4'h1..4'hE; err_cnt=14, fail_vec=4'h1, pass=0.
4. op=3'b110, start -> done in the cycle after acceptance, busy never high; pass=0, err_cnt=0, fail_valid=0.
5. Ideal NAND model, rst asserted while vec=4'h7 -> all outputs 0 immediately, no done pulse. After rst deasserts, a fresh run gives pass=1.
6. SETTLE=3, ideal XOR model, op=100; start pulsed again mid-run -> busy 48 cycles, a single done pulse, pass=1; the second start is ignored.
